// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, defaults and halt opcode
package fetch_unit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int QDEPTH_DEF = 4;
  localparam logic [3:0] HLT_OP_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP,
    ST_STOP,
    ST_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO with flush, used as the fetched-instruction queue
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as zero when empty so consumers never see stale entries
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM feeding a registered instruction queue
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter int              QDEPTH   = QDEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OP   = HLT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              hlt,
  output logic [ADDR_W-1:0] pc
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] req_addr, req_addr_nxt;
  logic              q_push, q_pop, q_flush, q_full, q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ENT_W-1:0]  q_head;
  logic              is_hlt;

  assign is_hlt = (imem_rdata[DATA_W-1 -: 4] == HLT_OP);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    req_addr_nxt = req_addr;
    q_push       = 1'b0;
    q_flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          q_flush = 1'b1;
          pc_nxt  = redirect_pc;
        end else if (!q_full) begin
          state_nxt    = ST_WAIT;
          req_addr_nxt = pc;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          q_flush   = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack) begin
          q_push    = 1'b1;
          pc_nxt    = pc + ADDR_W'(2);
          state_nxt = is_hlt ? ST_STOP : ST_IDLE;
        end
      end
      ST_DROP: begin
        // The stale request stays on the bus until its response drains
        if (redirect) begin
          q_flush = 1'b1;
          pc_nxt  = redirect_pc;
        end
        if (imem_ack) state_nxt = ST_IDLE;
      end
      ST_STOP: begin
        if (redirect) begin
          q_flush   = 1'b1;
          pc_nxt    = redirect_pc;
          state_nxt = ST_IDLE;
        end else if (q_pop && q_count == CNT_W'(1)) begin
          // Nothing is pushed after the halt entry, so the last pop is that entry
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  assign imem_req   = (state == ST_WAIT) || (state == ST_DROP);
  assign imem_addr  = req_addr;
  assign hlt        = (state == ST_HALT);
  assign inst_valid = ~q_empty;
  assign q_pop      = inst_valid & inst_ready;
  assign inst_pc    = q_head[ENT_W-1:DATA_W];
  assign inst       = q_head[DATA_W-1:0];

  fetch_queue #(
    .WIDTH(ENT_W),
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (q_flush),
    .push     (q_push),
    .push_data({pc, imem_rdata}),
    .pop      (q_pop),
    .pop_data (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

endmodule
